// File: rtl/outer_in_packer_pkg.sv
// Shared widths and payload types for the outer input packer and its FIFO.
package outer_in_packer_pkg;

    localparam int unsigned HostWordLen     = 32;
    localparam int unsigned BusWordLen      = 64;
    localparam int unsigned OuterInCMD_SIZE = 4;

    typedef struct packed {
        logic                  last;
        logic [BusWordLen-1:0] word;
    } busEntry_t;

    localparam int unsigned EntryLen = $bits(busEntry_t);

    // High half in the upper bits, low half first on the wire.
    function automatic logic [BusWordLen-1:0] packHalves(
        input logic [HostWordLen-1:0] hi,
        input logic [HostWordLen-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/outer_in_packer_if.sv
// Host half-word stream in, packed bus-word stream out, plus FIFO occupancy.
interface outer_in_packer_if #(
    parameter int unsigned Depth = 4
);
    import outer_in_packer_pkg::*;

    localparam int unsigned LevelLen = $clog2(Depth) + 1;

    logic [HostWordLen-1:0] i;
    logic                   i_isReady;
    logic                   i_canReceive;
    logic                   i_isLast;
    logic [BusWordLen-1:0]  o;
    logic                   o_isReady;
    logic                   o_canReceive;
    logic                   o_isLast;
    logic [LevelLen-1:0]    level;

    // Environment side: drives host half-words and downstream acceptance.
    modport master (
        output i, i_isReady, i_isLast, o_canReceive,
        input  i_canReceive, o, o_isReady, o_isLast, level
    );

    // Packer side.
    modport slave (
        input  i, i_isReady, i_isLast, o_canReceive,
        output i_canReceive, o, o_isReady, o_isLast, level
    );

endinterface

// File: rtl/outer_in_packer_bus_fifo.sv
// Small synchronous FIFO with occupancy counter; head reads as zero when empty.
module bus_fifo #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           wrData,
    input  logic                       pop,
    output logic [Width-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     level
);
    localparam int unsigned PtrLen   = $clog2(Depth);
    localparam int unsigned LevelLen = PtrLen + 1;

    logic [Width-1:0]  mem [Depth];
    logic [PtrLen-1:0] wrPtr;
    logic [PtrLen-1:0] rdPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (level == LevelLen'(Depth));
    assign empty  = (level == '0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrLen'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrLen'(1);
            end
            case ({doPush, doPop})
                2'b10:   level <= level + LevelLen'(1);
                2'b01:   level <= level - LevelLen'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/outer_in_packer.sv
// Packs pairs of 32-bit host half-words (low first) into 64-bit bus words and
// buffers them ahead of the outer input adapter.
module outer_in_packer
    import outer_in_packer_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic              clk,
    input  logic              rst,
    outer_in_packer_if.slave  bus
);
    logic [HostWordLen-1:0] lo;
    logic                   hv;
    logic                   full;
    logic                   empty;
    logic                   canReceive;
    logic                   accept;
    logic                   push;
    logic                   pop;
    busEntry_t              wrEntry;
    logic [EntryLen-1:0]    rdBits;
    busEntry_t              rdEntry;

    // Loading a low half never needs FIFO room; anything that pushes does.
    assign canReceive = (~hv & ~bus.i_isLast) | ~full;
    assign accept     = bus.i_isReady & canReceive;
    assign push       = accept & (hv | bus.i_isLast);
    assign pop        = ~empty & bus.o_canReceive;

    assign wrEntry.last = bus.i_isLast;
    assign wrEntry.word = hv ? packHalves(bus.i, lo)
                             : packHalves(HostWordLen'(0), bus.i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= '0;
            hv <= 1'b0;
        end else if (accept) begin
            if (hv) begin
                hv <= 1'b0;
            end else if (!bus.i_isLast) begin
                lo <= bus.i;
                hv <= 1'b1;
            end
        end
    end

    bus_fifo #(
        .Width (EntryLen),
        .Depth (Depth)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wrData (wrEntry),
        .pop    (pop),
        .rdData (rdBits),
        .full   (full),
        .empty  (empty),
        .level  (bus.level)
    );

    assign rdEntry          = busEntry_t'(rdBits);
    assign bus.o            = rdEntry.word;
    assign bus.o_isLast     = rdEntry.last;
    assign bus.o_isReady    = ~empty;
    assign bus.i_canReceive = canReceive;

endmodule

// File: doc/outer_in_packer.md
# outer_in_packer

Width-adapting ingress stage placed directly upstream of the outer input adapter. It accepts 32-bit half-words from the host link and packs consecutive pairs, low half first, into 64-bit bus words. The words are buffered in a small FIFO and presented on the `o__in` stream that the outer input adapter consumes. A host-marked last half-word closes the current word, zero-padding the high half if needed, and the word carries a last flag.

## Interface
Parameters:
- `Depth`, default 4: FIFO entries. Power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `i`  in  32  host half-word.
- `i_isReady`  in  1  `i` is valid.
- `i_canReceive`  out  1  the block accepts `i` this cycle.
- `i_isLast`  in  1  `i` is the final half-word of a message; qualified by `i_isReady`.
- `o`  out  64  packed word at the FIFO head.
- `o_isReady`  out  1  FIFO is non-empty.
- `o_canReceive`  in  1  downstream takes `o` this cycle.
- `o_isLast`  out  1  head word closes a message.
- `level`  out  clog2(Depth)+1  current FIFO occupancy.

## Operation
- **Transfers.** A transfer happens on a port when its `isReady` and `canReceive` are both 1 in the same cycle.
- **Hold state.**
  - `lo`: 32-bit register holding a pending low half.
  - `hv`: 1-bit flag, 1 when `lo` is pending.
- **Accepted input, `hv`=0, `i_isLast`=0.** Load `lo`<=`i`, set `hv`<=1. No push.
- **Accepted input, `hv`=0, `i_isLast`=1.** Push `{32'b0, i}` with last=1. `hv` stays 0.
- **Accepted input, `hv`=1.** Push `{i, lo}` with last=`i_isLast`. Clear `hv`<=0.
- **`i_canReceive`** = (`~hv` & `~i_isLast`) | `~full`.
  - It depends only on registered state and `i_isLast`.
  - There is no combinational path from `o_canReceive`.
- **FIFO.**
  - 65-bit entries: {last, word}.
  - Push and pop in the same cycle are allowed whenever the FIFO is not full.
  - When full, a push is refused even if a pop happens that cycle.
  - Read and write pointers are clog2(Depth) bits and wrap naturally.
  - `level` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- **Outputs.**
  - `o`, `o_isLast`: the head entry.
  - `o_isReady` = (`level` != 0).
- **Message boundaries.** No word ever mixes halves from two messages, because a last half-word always clears `hv`.
- **Reset (`rst`=1, at any time).**
  - `hv`, both pointers and `level` clear to 0 immediately (asynchronously).
  - Any pending half or buffered word is discarded.
  - Reset values: `o_isReady`=0, `level`=0, `i_canReceive`=1. `o` and `o_isLast` are don't-care while `o_isReady`=0; implement them as 0 when empty.

## Timing
- **Latency.** The half-word completing a word is accepted in cycle t; `o_isReady`=1 from cycle t+1 if the FIFO was empty.
- **Throughput.**
  - Sustained 32-bit input at one half-word per cycle yields one word every 2 cycles.
  - The output side can drain one word per cycle.
- **Boundary conditions.**
  - Full with `hv`=0 and `i_isLast`=0: input is still accepted (loads `lo`).
  - Full with `hv`=1: input is stalled until a pop registers.
  - Empty: `o_isReady`=0; `o_canReceive` is ignored.
- **Stability.** `o` must hold stable while `o_isReady`=1 and `o_canReceive`=0.

## Structure
- **Shared package.**
  - Constants `HostWordLen`=32 and `BusWordLen`=64.
  - `OuterInCMD_SIZE`, unchanged.
- **Sub-module.** One natural sub-module, `bus_fifo`.
  - Parameters: `Width` (65 here) and `Depth`.
  - Contains: asynchronous-reset pointers, occupancy counter, `full`/`empty` flags.
  - Reusable on the output side of the outer output adapter.
- **Packer.** The packing logic (`lo`, `hv`, push mux) stays in `outer_in_packer`.

## Test plan
- **Simple pair.** Reset, then send 0x11111111 and 0x22222222 with `i_isLast`=0,1.
  - Expect one word 0x22222222_11111111 with `o_isLast`=1.
  - Expect `o_isReady` in the cycle after the second accept.
- **Odd length.** Send 3 halves A, B, C with last on C.
  - Expect `{B,A}` with last=0, then `{0,C}` with last=1.
- **Backpressure.** Hold `o_canReceive`=0 and stream 2*Depth+1 non-last halves.
  - `level` reaches Depth and `i_canReceive` drops with `hv`=1.
  - Release: Depth words drain in Depth cycles, in order, with no loss.
- **Simultaneous push and pop.** With `level`=2, push and pop in the same cycle.
  - `level` stays 2.
  - Pointer wrap after 3*Depth words yields correct ordering.
- **Single-half message.** `i_isLast`=1 while `hv`=0 and the FIFO is full.
  - `i_canReceive`=0 until a pop, then the word `{0,i}` with last=1 is pushed.
- **Reset mid-operation.** Assert `rst` with `hv`=1 and `level`=3.
  - Outputs clear immediately.
  - After release, a new pair packs without the stale low half.
